// File: rtl/instr_fetch_if.sv
// instr_fetch_if: ROM and decoder signals between the fetch sequencer and its surroundings
interface instr_fetch_if #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
);
  logic             Start;
  logic [8:0]       rom_data;
  logic             branch_ne;
  logic             halt;
  logic [PC_W-1:0]  lut_target;
  logic [PC_W-1:0]  rom_addr;
  logic [8:0]       instruction;
  logic             read_jump;
  logic             done;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] instr_count;
  modport master (
    input  Start, rom_data, branch_ne, halt, lut_target,
    output rom_addr, instruction, read_jump, done, cycle_count, instr_count
  );
  modport slave (
    output Start, rom_data, branch_ne, halt, lut_target,
    input  rom_addr, instruction, read_jump, done, cycle_count, instr_count
  );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: program counter and fetch sequencer with BNE target-word handling and run statistics
module instr_fetch #(
  parameter int PC_W       = 10,
  parameter int START_ADDR = 0,
  parameter int CNT_W      = 16
) (
  input logic Clk,
  input logic Reset,
  instr_fetch_if.master bus
);
  typedef enum logic [1:0] {IDLE, RUN, JUMP, HALTED} state_t;
  localparam logic [PC_W-1:0] START = PC_W'(START_ADDR);
  state_t           state, state_n;
  logic [PC_W-1:0]  pc, pc_n;
  logic [CNT_W-1:0] cyc, cyc_n, cyc_inc, ins, ins_n, ins_inc;
  logic             bne, taken, jump_q, done_q;
  assign bne     = bus.rom_data[8:6] == 3'b111;
  assign taken   = bne && bus.branch_ne;
  assign cyc_inc = &cyc ? cyc : cyc + 1'b1;
  assign ins_inc = &ins ? ins : ins + 1'b1;
  always_comb begin
    state_n = state;
    pc_n    = pc;
    cyc_n   = cyc;
    ins_n   = ins;
    case (state)
      IDLE, HALTED: begin
        if (bus.Start) begin
          state_n = RUN;
          pc_n    = START;
          cyc_n   = '0;
          ins_n   = '0;
        end
      end
      RUN: begin
        cyc_n = cyc_inc;
        if (bus.halt) state_n = HALTED;
        else begin
          ins_n   = ins_inc;
          state_n = taken ? JUMP : RUN;
          // a not-taken BNE skips its target word
          pc_n    = pc + ((bne && !taken) ? PC_W'(2) : PC_W'(1));
        end
      end
      default: begin
        cyc_n   = cyc_inc;
        ins_n   = ins_inc;
        pc_n    = bus.lut_target;
        state_n = RUN;
      end
    endcase
  end
  // read_jump and done come straight from flops so the decoder sees no glitches
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state  <= IDLE;
      pc     <= START;
      cyc    <= '0;
      ins    <= '0;
      jump_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      cyc    <= cyc_n;
      ins    <= ins_n;
      jump_q <= state_n == JUMP;
      done_q <= state_n == HALTED;
    end
  end
  assign bus.rom_addr    = pc;
  assign bus.instruction = bus.rom_data;
  assign bus.read_jump   = jump_q;
  assign bus.done        = done_q;
  assign bus.cycle_count = cyc;
  assign bus.instr_count = ins;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed checks of fetch sequencing, BNE handling, halt/restart, wrap and saturation
module tb_instr_fetch;
  logic Clk = 1'b0;
  logic Reset = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  logic [8:0] rom_m [1024];
  logic [8:0] rom_s [16];
  instr_fetch_if #(.PC_W(10), .CNT_W(16)) m ();
  instr_fetch_if #(.PC_W(4), .CNT_W(4)) s ();
  instr_fetch #(.PC_W(10), .START_ADDR(0), .CNT_W(16)) dut_m (.Clk(Clk), .Reset(Reset), .bus(m.master));
  instr_fetch #(.PC_W(4), .START_ADDR(0), .CNT_W(4)) dut_s (.Clk(Clk), .Reset(Reset), .bus(s.master));
  always #5 Clk = ~Clk;
  assign m.rom_data = rom_m[m.rom_addr];
  assign s.rom_data = rom_s[s.rom_addr];
  assign m.halt = (m.rom_data == 9'h180) && !m.read_jump;
  assign s.halt = 1'b0;
  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask
  task automatic apply_reset();
    Reset = 1'b0;
    #2;
    Reset = 1'b1;
  endtask
  task automatic start_main();
    m.Start = 1'b1;
    step(1);
    m.Start = 1'b0;
  endtask
  task automatic test_reset();
    step(1);
    apply_reset();
    n_checks++;
    if (m.rom_addr !== 10'd0 || m.read_jump !== 1'b0 || m.done !== 1'b0 || m.cycle_count !== 16'd0 || m.instr_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_state got addr=%0d rj=%b done=%b cyc=%0d ins=%0d want 0 0 0 0 0", m.rom_addr, m.read_jump, m.done, m.cycle_count, m.instr_count);
    end
    step(2);
    n_checks++;
    if (m.rom_addr !== 10'd0 || m.cycle_count !== 16'd0) begin
      n_fail++;
      $display("FAIL idle_hold got addr=%0d cyc=%0d want 0 0", m.rom_addr, m.cycle_count);
    end
  endtask
  task automatic test_sequential();
    start_main();
    n_checks++;
    if (m.rom_addr !== 10'd0 || m.cycle_count !== 16'd0 || m.instr_count !== 16'd0) begin
      n_fail++;
      $display("FAIL seq_start got addr=%0d cyc=%0d ins=%0d want 0 0 0", m.rom_addr, m.cycle_count, m.instr_count);
    end
    step(1);
    n_checks++;
    if (m.rom_addr !== 10'd1) begin
      n_fail++;
      $display("FAIL seq_pc1 got %0d want 1", m.rom_addr);
    end
    step(1);
    n_checks++;
    if (m.rom_addr !== 10'd2) begin
      n_fail++;
      $display("FAIL seq_pc2 got %0d want 2", m.rom_addr);
    end
    step(1);
    n_checks++;
    if (m.rom_addr !== 10'd3 || m.cycle_count !== 16'd3 || m.instr_count !== 16'd3) begin
      n_fail++;
      $display("FAIL seq_counts got addr=%0d cyc=%0d ins=%0d want 3 3 3", m.rom_addr, m.cycle_count, m.instr_count);
    end
  endtask
  task automatic test_bne_taken();
    apply_reset();
    start_main();
    step(5);
    m.branch_ne = 1'b1;
    n_checks++;
    if (m.rom_addr !== 10'd5 || m.instruction !== 9'h1C1 || m.read_jump !== 1'b0) begin
      n_fail++;
      $display("FAIL taken_at_bne got addr=%0d instr=%h rj=%b want 5 1c1 0", m.rom_addr, m.instruction, m.read_jump);
    end
    step(1);
    m.branch_ne = 1'b0;
    n_checks++;
    if (m.rom_addr !== 10'd6 || m.read_jump !== 1'b1 || m.instr_count !== 16'd6) begin
      n_fail++;
      $display("FAIL taken_jump got addr=%0d rj=%b ins=%0d want 6 1 6", m.rom_addr, m.read_jump, m.instr_count);
    end
    step(1);
    n_checks++;
    if (m.rom_addr !== 10'd40 || m.read_jump !== 1'b0 || m.instr_count !== 16'd7 || m.cycle_count !== 16'd7) begin
      n_fail++;
      $display("FAIL taken_target got addr=%0d rj=%b ins=%0d cyc=%0d want 40 0 7 7", m.rom_addr, m.read_jump, m.instr_count, m.cycle_count);
    end
  endtask
  task automatic test_bne_not_taken_halt();
    apply_reset();
    start_main();
    step(5);
    m.branch_ne = 1'b0;
    step(1);
    n_checks++;
    if (m.rom_addr !== 10'd7 || m.read_jump !== 1'b0 || m.instr_count !== 16'd6) begin
      n_fail++;
      $display("FAIL nottaken_skip got addr=%0d rj=%b ins=%0d want 7 0 6", m.rom_addr, m.read_jump, m.instr_count);
    end
    step(2);
    n_checks++;
    if (m.rom_addr !== 10'd9 || m.done !== 1'b0 || m.instr_count !== 16'd8) begin
      n_fail++;
      $display("FAIL halt_word got addr=%0d done=%b ins=%0d want 9 0 8", m.rom_addr, m.done, m.instr_count);
    end
    step(1);
    n_checks++;
    if (m.rom_addr !== 10'd9 || m.done !== 1'b1 || m.cycle_count !== 16'd9 || m.instr_count !== 16'd8) begin
      n_fail++;
      $display("FAIL halted got addr=%0d done=%b cyc=%0d ins=%0d want 9 1 9 8", m.rom_addr, m.done, m.cycle_count, m.instr_count);
    end
    step(10);
    n_checks++;
    if (m.rom_addr !== 10'd9 || m.done !== 1'b1 || m.cycle_count !== 16'd9 || m.instr_count !== 16'd8) begin
      n_fail++;
      $display("FAIL halt_frozen got addr=%0d done=%b cyc=%0d ins=%0d want 9 1 9 8", m.rom_addr, m.done, m.cycle_count, m.instr_count);
    end
    m.Start = 1'b1;
    step(1);
    n_checks++;
    if (m.rom_addr !== 10'd0 || m.done !== 1'b0 || m.cycle_count !== 16'd0 || m.instr_count !== 16'd0) begin
      n_fail++;
      $display("FAIL restart got addr=%0d done=%b cyc=%0d ins=%0d want 0 0 0 0", m.rom_addr, m.done, m.cycle_count, m.instr_count);
    end
    step(1);
    m.Start = 1'b0;
    n_checks++;
    if (m.rom_addr !== 10'd1 || m.instr_count !== 16'd1) begin
      n_fail++;
      $display("FAIL start_ignored_run got addr=%0d ins=%0d want 1 1", m.rom_addr, m.instr_count);
    end
  endtask
  task automatic test_wrap_saturate();
    apply_reset();
    s.Start = 1'b1;
    step(1);
    s.Start = 1'b0;
    step(15);
    n_checks++;
    if (s.rom_addr !== 4'd15 || s.cycle_count !== 4'd15 || s.instr_count !== 4'd15) begin
      n_fail++;
      $display("FAIL small_pc15 got addr=%0d cyc=%0d ins=%0d want 15 15 15", s.rom_addr, s.cycle_count, s.instr_count);
    end
    step(1);
    n_checks++;
    if (s.rom_addr !== 4'd1 || s.cycle_count !== 4'd15 || s.instr_count !== 4'd15) begin
      n_fail++;
      $display("FAIL pc_wrap got addr=%0d cyc=%0d ins=%0d want 1 15 15", s.rom_addr, s.cycle_count, s.instr_count);
    end
    step(4);
    n_checks++;
    if (s.rom_addr !== 4'd5 || s.cycle_count !== 4'd15 || s.instr_count !== 4'd15) begin
      n_fail++;
      $display("FAIL saturate got addr=%0d cyc=%0d ins=%0d want 5 15 15", s.rom_addr, s.cycle_count, s.instr_count);
    end
  endtask
  task automatic test_reset_mid_jump();
    apply_reset();
    start_main();
    step(5);
    m.branch_ne = 1'b1;
    step(1);
    m.branch_ne = 1'b0;
    n_checks++;
    if (m.read_jump !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_jump got rj=%b want 1", m.read_jump);
    end
    #2;
    Reset = 1'b0;
    #1;
    n_checks++;
    if (m.rom_addr !== 10'd0 || m.read_jump !== 1'b0 || m.done !== 1'b0 || m.cycle_count !== 16'd0 || m.instr_count !== 16'd0) begin
      n_fail++;
      $display("FAIL async_reset got addr=%0d rj=%b done=%b cyc=%0d ins=%0d want 0 0 0 0 0", m.rom_addr, m.read_jump, m.done, m.cycle_count, m.instr_count);
    end
    #1;
    Reset = 1'b1;
    step(3);
    n_checks++;
    if (m.rom_addr !== 10'd0 || m.read_jump !== 1'b0 || m.cycle_count !== 16'd0 || m.instr_count !== 16'd0) begin
      n_fail++;
      $display("FAIL post_reset_idle got addr=%0d rj=%b cyc=%0d ins=%0d want 0 0 0 0", m.rom_addr, m.read_jump, m.cycle_count, m.instr_count);
    end
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) rom_m[i] = 9'h000;
    for (int i = 0; i < 16; i++) rom_s[i] = 9'h000;
    rom_m[5] = 9'h1C1;
    rom_m[6] = 9'h001;
    rom_m[9] = 9'h180;
    rom_s[15] = 9'h1C0;
    m.Start = 1'b0;
    m.branch_ne = 1'b0;
    m.lut_target = 10'd40;
    s.Start = 1'b0;
    s.branch_ne = 1'b0;
    s.lut_target = 4'd0;
    test_reset();
    test_sequential();
    test_bne_taken();
    test_bne_not_taken_halt();
    test_wrap_saturate();
    test_reset_mid_jump();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Program-counter and fetch sequencer for the 9-bit single-cycle processor. It sits directly upstream of the control decoder. It drives the instruction ROM address and forwards the fetched word to the decoder, together with the `read_jump` qualifier. It also sequences the two-word BNE/jump-target pair, and handles start, halt and run-statistics counting.

## Interface
- `PC_W`, 10, program counter / ROM address width
- `START_ADDR`, 0, PC value loaded on reset and on Start
- `CNT_W`, 16, width of the cycle and instruction counters
- `Clk`  in  1  sole clock, all state updates on rising edge
- `Reset`  in  1  asynchronous, active-low reset
- `Start`  in  1  level-sampled start/restart request
- `rom_data`  in  9  instruction ROM read data at `rom_addr` (combinational ROM)
- `branch_ne`  in  1  ALU result: BNE operands unequal (valid when current word is BNE)
- `halt`  in  1  decoder Halt for current word
- `lut_target`  in  PC_W  jump target from LUT, indexed by current word's `[5:0]`
- `rom_addr`  out  PC_W  current PC
- `instruction`  out  9  = `rom_data`, to decoder
- `read_jump`  out  1  current word is a jump-target word
- `done`  out  1  program halted
- `cycle_count`  out  CNT_W  cycles spent in RUN or JUMP
- `instr_count`  out  CNT_W  words retired

## Operation
- States:
  - IDLE: after reset, waiting for Start.
  - RUN: normal fetch.
  - JUMP: current word is a jump target.
  - HALTED: program stopped.
- `read_jump` = 1 only in JUMP. `done` = 1 only in HALTED. Both are decoded from the state register and are glitch-free.
- A word is a BNE when `rom_data[8:6]` = 3'b111, decoded locally. The word at PC+1 after every BNE is its jump-target word.
- IDLE: PC held at START_ADDR, counters held.
  - Start=1: go to RUN. PC = START_ADDR, both counters = 0.
- RUN, priority order:
  1. halt=1: go to HALTED, PC held.
  2. BNE and branch_ne=1: go to JUMP, PC+1.
  3. BNE and branch_ne=0: stay in RUN, PC+2 (target word skipped, not retired).
  4. Otherwise: stay in RUN, PC+1.
- JUMP: PC = `lut_target`, go to RUN. `halt` is ignored in JUMP; the decoder never asserts it with `read_jump` set.
- HALTED: PC and counters frozen.
  - Start=1: restart, behaving identically to Start in IDLE.
- Start in RUN or JUMP: ignored.
- PC arithmetic is modulo 2^PC_W. PC+1 and PC+2 wrap silently, e.g. PC=1023 with PC+2 gives 1.
- `cycle_count` increments every cycle in RUN or JUMP. It saturates at all-ones; it does not wrap.
- `instr_count` increments on each word retired, saturating at all-ones:
  - each RUN cycle not taking the halt path, +1;
  - each JUMP cycle, +1;
  - the halting word is not counted.

## Timing
- Fetch is zero-latency: `instruction` = `rom_data` for the current PC in the same cycle.
- The next PC is visible on `rom_addr` after the rising edge that retires the current word.
- A taken BNE costs 2 cycles to reach its target: BNE cycle, then JUMP cycle, then target in RUN. A not-taken BNE costs 1 cycle.
- `done` rises on the edge after the cycle in which `halt` is sampled high.
- Reset (asynchronous, Reset=0), at any time including mid-JUMP, immediately forces:
  - state IDLE, `rom_addr` = START_ADDR;
  - `read_jump` = 0, `done` = 0, `cycle_count` = 0, `instr_count` = 0.
- Reset release is synchronous to Clk. The first Start is sampled on the first rising edge after release.

## Test plan
- Reset, then Start pulse → `rom_addr` 0, 1, 2 on successive edges. Words 0–2 are ADD; `cycle_count` = 3 and `instr_count` = 3 after the 3rd edge.
- BNE at PC 5 with branch_ne=1 and `lut_target` = 40 → PC 6 with `read_jump` = 1 for one cycle, then PC 40 with `read_jump` = 0.
- BNE at PC 5 with branch_ne=0 → next PC 7; `read_jump` never asserted; `instr_count` +1.
- Halt word at PC 9 → `done` = 1 next cycle; PC stays 9 and counters freeze across 10 idle cycles. Start then → PC 0, counters 0, `done` = 0.
- PC_W=4: a not-taken BNE at PC 15 → PC 1. With CNT_W=4, run 20 cycles → `cycle_count` holds 15.
- Assert Reset low during the JUMP cycle → outputs reach reset values without a clock edge. After release, no activity until Start.
